wb_stage: RTL

Write-back stage of the GenshinCPU integer pipeline, directly downstream of MEM2. It registers the MEM2 outputs and produces the data for the register-file, HI and LO write ports. It extracts and extends load data, including the LWL/LWR merge, and provides the forwarding value. It also drives the debug trace with one-shot write enables so that a stalled instruction is traced only once, and keeps a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 46 ++++
 rtl/wb_stage_if.sv | 27 ++
 rtl/wb_stage_load_align.sv | 49 ++++
 rtl/wb_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions for the write-back stage: load-type encoding,
// register-write control bundle, write-back source selects and the stage
// register layout.
package wb_stage_pkg;

  // Load-type encoding carried down the pipeline with each instruction.
  typedef enum logic [2:0] {
    LT_NONE = 3'd0,
    LB      = 3'd1,
    LBU     = 3'd2,
    LH      = 3'd3,
    LHU     = 3'd4,
    LW      = 3'd5,
    LWL     = 3'd6,
    LWR     = 3'd7
  } load_type_e;

  // Write controls, packed MSB first as {RFWr, CP0Wr, HIWr, LOWr}.
  typedef struct packed {
    logic rf_wr;
    logic cp0_wr;
    logic hi_wr;
    logic lo_wr;
  } regs_wr_t;

  // Write-back source selects.
  localparam logic [1:0] WB_PC8  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_OUTB = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  // Contents of the MEM2/WB stage register.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dst;
    regs_wr_t    regs_wr;
    logic [1:0]  wb_sel;
    load_type_e  load_type;
    logic [31:0] result;
    logic [31:0] dm_out;
    logic [31:0] out_b;
    logic [1:0]  addr_lo;
  } stage_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM2 -> WB bundle. The master modport is the MEM2 stage, which drives
// every field. The slave modport is the write-back stage, which only reads.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic        MEM2_Valid;      // MEM2 holds a real instruction
  logic [31:0] MEM2_PC;         // PC of that instruction
  logic [4:0]  MEM2_Dst;        // destination GPR
  logic [3:0]  MEM2_RegsWrType; // {RFWr, CP0Wr, HIWr, LOWr}
  logic [1:0]  MEM2_WbSel;      // 11 selects load data
  load_type_e  MEM2_LoadType;   // load-type encoding
  logic [31:0] MEM2_Result;     // non-load result
  logic [31:0] MEM2_DMOut;      // raw data-cache read word
  logic [31:0] MEM2_OutB;       // old rt value for the LWL/LWR merge
  logic [1:0]  MEM2_AddrLo;     // ALUOut[1:0]

  modport master (
    output MEM2_Valid, MEM2_PC, MEM2_Dst, MEM2_RegsWrType, MEM2_WbSel,
           MEM2_LoadType, MEM2_Result, MEM2_DMOut, MEM2_OutB, MEM2_AddrLo
  );

  modport slave (
    input  MEM2_Valid, MEM2_PC, MEM2_Dst, MEM2_RegsWrType, MEM2_WbSel,
           MEM2_LoadType, MEM2_Result, MEM2_DMOut, MEM2_OutB, MEM2_AddrLo
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load-data extraction and extension.
// Ports: load_type/addr_lo select the access; dm_out is the raw cache word;
// out_b is the old rt value merged in by LWL/LWR; data is the GPR value.
module load_align
  import wb_stage_pkg::*;
(
  input  load_type_e  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] dm_out,
  input  logic [31:0] out_b,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dm_out[{addr_lo, 3'b000} +: 8];
  // A misaligned halfword traps upstream, so only addr_lo[1] matters here.
  assign half_sel = addr_lo[1] ? dm_out[31:16] : dm_out[15:0];

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    data = dm_out;
    unique case (load_type)
      LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LBU: data = {24'h0, byte_sel};
      LH:  data = {{16{half_sel[15]}}, half_sel};
      LHU: data = {16'h0, half_sel};
      LWL: begin
        unique case (addr_lo)
          2'd0: data = {dm_out[7:0],  out_b[23:0]};
          2'd1: data = {dm_out[15:0], out_b[15:0]};
          2'd2: data = {dm_out[23:0], out_b[7:0]};
          2'd3: data = dm_out;
        endcase
      end
      LWR: begin
        unique case (addr_lo)
          2'd0: data = dm_out;
          2'd1: data = {out_b[31:24], dm_out[31:8]};
          2'd2: data = {out_b[31:16], dm_out[31:16]};
          2'd3: data = {out_b[31:8],  dm_out[31:24]};
        endcase
      end
      default: data = dm_out; // LW and LT_NONE
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers MEM2 outputs, produces GPR/HI/LO write-port
// data, drives the debug trace with one-shot enables, counts retirements.
// Ports: clk/resetn (sync, active low); WB_Flush loads a bubble; WB_Wr is
// the stage enable; mem2 is the MEM2 bundle; WB_* are write-port outputs;
// debug_wb_* is the trace; WB_RetireCnt counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        WB_Flush,
  input  logic        WB_Wr,
  wb_stage_if.slave   mem2,
  output logic        WB_RFWr,
  output logic [4:0]  WB_Dst,
  output logic [31:0] WB_Result,
  output logic        WB_HIWr,
  output logic        WB_LOWr,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] WB_RetireCnt
);

  stage_t      stage_q;
  stage_t      stage_d;
  logic        fresh_q;
  logic        fresh_d;
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_cnt_next;
  logic [31:0] load_data;
  logic        unused;

  always_comb begin
    stage_d           = '0;
    stage_d.valid     = mem2.MEM2_Valid;
    stage_d.pc        = mem2.MEM2_PC;
    stage_d.dst       = mem2.MEM2_Dst;
    stage_d.regs_wr   = regs_wr_t'(mem2.MEM2_RegsWrType);
    stage_d.wb_sel    = mem2.MEM2_WbSel;
    stage_d.load_type = mem2.MEM2_LoadType;
    stage_d.result    = mem2.MEM2_Result;
    stage_d.dm_out    = mem2.MEM2_DMOut;
    stage_d.out_b     = mem2.MEM2_OutB;
    stage_d.addr_lo   = mem2.MEM2_AddrLo;
  end

  // fresh marks the first cycle a real instruction sits in the stage; hold
  // cycles clear it so a stalled instruction is traced and counted once.
  assign fresh_d         = WB_Wr & ~WB_Flush & mem2.MEM2_Valid;
  assign retire_cnt_next = retire_cnt_q + {31'd0, fresh_d};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      stage_q      <= '0;
      fresh_q      <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (WB_Flush) begin
        // Bubble: only valid and the write controls matter; data is stale.
        stage_q.valid   <= 1'b0;
        stage_q.regs_wr <= '0;
      end else if (WB_Wr) begin
        stage_q <= stage_d;
      end
      fresh_q      <= fresh_d;
      retire_cnt_q <= retire_cnt_next;
    end
  end

  load_align u_load_align (
    .load_type (stage_q.load_type),
    .addr_lo   (stage_q.addr_lo),
    .dm_out    (stage_q.dm_out),
    .out_b     (stage_q.out_b),
    .data      (load_data)
  );

  assign WB_RFWr   = stage_q.valid & stage_q.regs_wr.rf_wr;
  assign WB_HIWr   = stage_q.valid & stage_q.regs_wr.hi_wr;
  assign WB_LOWr   = stage_q.valid & stage_q.regs_wr.lo_wr;
  assign WB_Dst    = stage_q.dst;
  assign WB_Result = (stage_q.wb_sel == WB_LOAD) ? load_data : stage_q.result;

  assign debug_wb_pc       = stage_q.pc;
  assign debug_wb_rf_wen   = {4{fresh_q & WB_RFWr}};
  assign debug_wb_rf_wnum  = stage_q.dst;
  assign debug_wb_rf_wdata = WB_Result;
  assign WB_RetireCnt      = retire_cnt_q;

  // CP0 writes are committed by MEM2; the bit is carried only for the flush.
  assign unused = stage_q.regs_wr.cp0_wr;

endmodule
